// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- shared definitions for the pipeline hazard / run-control block.
//   run_state_t : run-control FSM states; the encoding is visible on run_state.
//   FWD_*       : forwarding-mux select codes driven on fwd_a / fwd_b.
//   dst_match() : "a register write to dst is visible to a reader of src".
//                 Register 0 is hard-wired, so it never matches.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10,
        STEP   = 2'b11
    } run_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    function automatic logic dst_match(input logic       wr,
                                       input logic [4:0] dst,
                                       input logic [4:0] src);
        return wr && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/run_ctrl_fsm.sv
// run_ctrl_fsm -- debug run-control for the pipeline.
//   RUN    : normal fetch; halt_req starts a drain.
//   DRAIN  : fetch stopped and IF/ID flushed for DRAIN_CYC cycles so the
//            ID/EX/MEM/WB stages empty, then HALTED.
//   HALTED : fetch stopped; run_req resumes, step_req fetches one instruction
//            (run_req wins when both arrive together).
//   STEP   : exactly one fetch cycle, then drain again.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   halt_req, step_req, run_req  run-control pulses
//   state                        current state (encoding from pipeline_pkg)
//   fetch_en                     1 when PC / IF-ID may advance (RUN, STEP)
//   drain_flush                  1 while draining (IF/ID must be flushed)
module run_ctrl_fsm
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       halt_req,
    input  logic       step_req,
    input  logic       run_req,
    output run_state_t state,
    output logic       fetch_en,
    output logic       drain_flush
);

    localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);

    logic [CW-1:0] drain_cnt_reg;

    // Outputs are registered alongside the state so that they are glitch-free
    // and already correct in the first cycle of each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            drain_cnt_reg <= '0;
            fetch_en      <= 1'b1;
            drain_flush   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state         <= DRAIN;
                        drain_cnt_reg <= DRAIN_LAST;
                        fetch_en      <= 1'b0;
                        drain_flush   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == '0) begin
                        state       <= HALTED;
                        drain_flush <= 1'b0;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 1'b1;
                    end
                end
                HALTED: begin
                    if (run_req) begin
                        state    <= RUN;
                        fetch_en <= 1'b1;
                    end else if (step_req) begin
                        state    <= STEP;
                        fetch_en <= 1'b1;
                    end
                end
                STEP: begin
                    state         <= DRAIN;
                    drain_cnt_reg <= DRAIN_LAST;
                    fetch_en      <= 1'b0;
                    drain_flush   <= 1'b1;
                end
                default: begin
                    state       <= RUN;
                    fetch_en    <= 1'b1;
                    drain_flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard detection, flush, forwarding and run control for a
// classic 5-stage MIPS pipeline.
// Build option: PIPELINE_CTRL_FWD_EN
//   defined   : EX/MEM and MEM/WB forwarding; only load-use stalls.
//   undefined : no forwarding (fwd_a/fwd_b stay 00); any pending write to a
//               source register in ID/EX or EX/MEM stalls until it clears.
// Ports:
//   id_rs, id_rt, id_uses_rt           sources of the instruction in IF/ID
//   idex_memread/regwrite/dst          instruction in ID/EX
//   exmem_regwrite/dst, memwb_*        writers in EX/MEM and MEM/WB
//   pcsrc (taken branch in MEM), jump (jump in ID)
//   halt_req, step_req, run_req        debug run control
//   pc_write, ifid_write               PC / IF-ID enables
//   ifid_flush, idex_flush, exmem_flush
//   fwd_a, fwd_b                       ALU operand select (00 RF, 01 MEM/WB, 10 EX/MEM)
//   run_state, stall_cnt, flush_cnt    status and saturating statistics
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic             idex_regwrite,
    input  logic [4:0]       idex_dst,
    input  logic             exmem_regwrite,
    input  logic [4:0]       exmem_dst,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_dst,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             run_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       run_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    run_state_t fsm_state;
    logic       fetch_en;
    logic       drain_flush;

    run_ctrl_fsm #(.DRAIN_CYC(DRAIN_CYC)) u_run_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .run_req     (run_req),
        .state       (fsm_state),
        .fetch_en    (fetch_en),
        .drain_flush (drain_flush)
    );

    assign run_state = fsm_state;

    logic live;          // hazard / flush logic is active
    logic lu_done_reg;   // a load-use stall was taken last cycle
    logic load_use;
    logic raw_hazard;
    logic hazard;
    logic branch;
    logic jmp;
    logic stall;
    logic unused_ok;

    // Gating with rst_n makes the combinational outputs take their reset
    // values as soon as reset asserts. A halted pipeline is empty, so hazard
    // and flush requests are ignored there (which also keeps the counters still).
    assign live = rst_n && (fsm_state != HALTED);

    always_comb begin
        // One-shot: the stall inserts a bubble into ID/EX, so the same load
        // never needs a second stall cycle.
        load_use = idex_memread && !lu_done_reg &&
                   (dst_match(1'b1, idex_dst, id_rs) ||
                    (id_uses_rt && dst_match(1'b1, idex_dst, id_rt)));
`ifdef PIPELINE_CTRL_FWD_EN
        raw_hazard = 1'b0;
`else
        // Without forwarding every in-flight writer of a source must retire
        // first. MEM/WB is excluded: the register file writes before it reads.
        raw_hazard = (dst_match(idex_regwrite,  idex_dst,  id_rs) ||
                      (id_uses_rt && dst_match(idex_regwrite,  idex_dst,  id_rt))) ||
                     (dst_match(exmem_regwrite, exmem_dst, id_rs) ||
                      (id_uses_rt && dst_match(exmem_regwrite, exmem_dst, id_rt)));
`endif
        hazard = live && (load_use || raw_hazard);
        branch = live && pcsrc;
        jmp    = live && jump;
        // A taken branch discards the stalled instruction, so it wins.
        stall  = hazard && !branch;
    end

    assign pc_write    = fetch_en && !stall;
    assign ifid_write  = fetch_en && !stall;
    assign ifid_flush  = drain_flush || branch || jmp;
    assign idex_flush  = hazard || branch;
    assign exmem_flush = branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_done_reg <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            lu_done_reg <= live && load_use && !branch;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((branch || jmp) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

`ifdef PIPELINE_CTRL_FWD_EN
    logic [4:0] src_id  [2];
    logic [1:0] fwd_sel [2];

    assign src_id[0] = id_rs;
    assign src_id[1] = id_rt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        // Copy of the source register that travels with the instruction into
        // ID/EX; a bubble carries register 0, which never forwards.
        logic [4:0] src_ex_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                src_ex_reg <= '0;
            end else begin
                src_ex_reg <= idex_flush ? 5'd0 : src_id[gi];
            end
        end

        // EX/MEM holds the younger result, so it has priority.
        assign fwd_sel[gi] = dst_match(exmem_regwrite, exmem_dst, src_ex_reg) ? FWD_EXMEM :
                             dst_match(memwb_regwrite, memwb_dst, src_ex_reg) ? FWD_MEMWB :
                             FWD_RF;
    end

    assign fwd_a     = fwd_sel[0];
    assign fwd_b     = fwd_sel[1];
    assign unused_ok = idex_regwrite;
`else
    assign fwd_a     = FWD_RF;
    assign fwd_b     = FWD_RF;
    assign unused_ok = ^{memwb_regwrite, memwb_dst};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl -- self-checking bench for pipeline_ctrl.
// Table of single-cycle hazard vectors, hand-written multi-cycle sequences,
// then randomized stimulus compared every cycle with a behavioural model.
// Compile with or without PIPELINE_CTRL_FWD_EN; expectations follow the build.
module tb_pipeline_ctrl;

    localparam int CNT_W     = 5;
    localparam int DRAIN_CYC = 4;
    localparam int CMAX      = (1 << CNT_W) - 1;
`ifdef PIPELINE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [4:0]       id_rs, id_rt, idex_dst, exmem_dst, memwb_dst;
    logic             id_uses_rt, idex_memread, idex_regwrite;
    logic             exmem_regwrite, memwb_regwrite, pcsrc, jump;
    logic             halt_req, step_req, run_req;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]       fwd_a, fwd_b, run_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .idex_dst(idex_dst),
        .exmem_regwrite(exmem_regwrite), .exmem_dst(exmem_dst),
        .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst),
        .pcsrc(pcsrc), .jump(jump),
        .halt_req(halt_req), .step_req(step_req), .run_req(run_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .run_state(run_state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    int         m_drain_left;   // drain cycles still to go (0 = not draining)
    bit         m_halted;
    bit         m_step;
    bit         m_lu_prev;      // load-use stall taken in previous cycle
    logic [4:0] m_src_ex [2];   // rs/rt of instruction now in EX
    int         m_stall, m_flush;

    bit e_pc, e_ifidf, e_idexf, e_exmemf, e_stall, e_lu_fire, e_cnt_flush;
    int e_fwd_a, e_fwd_b, e_state;

    function automatic bit hits(logic [4:0] d);
        return (d != 0) && ((d == id_rs) || (id_uses_rt && (d == id_rt)));
    endfunction

    function automatic int fwd_of(logic [4:0] src);
        if (exmem_regwrite && exmem_dst != 0 && exmem_dst == src) return 2;
        if (memwb_regwrite && memwb_dst != 0 && memwb_dst == src) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_drain_left = 0; m_halted = 0; m_step = 0; m_lu_prev = 0;
        m_src_ex[0] = 0; m_src_ex[1] = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic calc();
        bit live, fetch_ok, lu, raw, haz, br, jp;
        live     = rst_n && !m_halted;
        fetch_ok = !m_halted && (m_drain_left == 0);
        lu       = idex_memread && hits(idex_dst) && !m_lu_prev;
        raw      = !FWD && ((idex_regwrite && hits(idex_dst)) ||
                            (exmem_regwrite && hits(exmem_dst)));
        haz = live && (lu || raw);
        br  = live && pcsrc;
        jp  = live && jump;
        e_stall     = haz && !br;
        e_lu_fire   = live && lu && !br;
        e_pc        = fetch_ok && !e_stall;
        e_ifidf     = (m_drain_left > 0) || br || jp;
        e_idexf     = haz || br;
        e_exmemf    = br;
        e_cnt_flush = br || jp;
        e_fwd_a = FWD ? fwd_of(m_src_ex[0]) : 0;
        e_fwd_b = FWD ? fwd_of(m_src_ex[1]) : 0;
        e_state = m_halted ? 2 : (m_drain_left > 0) ? 1 : m_step ? 3 : 0;
    endtask

    task automatic model_step();
        calc();
        m_lu_prev = e_lu_fire;
        if (e_stall && m_stall < CMAX) m_stall++;
        if (e_cnt_flush && m_flush < CMAX) m_flush++;
        m_src_ex[0] = e_idexf ? 5'd0 : id_rs;
        m_src_ex[1] = e_idexf ? 5'd0 : id_rt;
        if (m_halted) begin
            if (run_req) m_halted = 0;
            else if (step_req) begin m_halted = 0; m_step = 1; end
        end else if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
        end else if (m_step) begin
            m_step = 0; m_drain_left = DRAIN_CYC;
        end else if (halt_req) begin
            m_drain_left = DRAIN_CYC;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string nm, int act, int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    task automatic compare_all();
        calc();
        $display("t=%0t st=%0d pcw=%0d ifw=%0d fl=%0d%0d%0d fwd=%0d/%0d scnt=%0d fcnt=%0d",
                 $time, run_state, pc_write, ifid_write, ifid_flush, idex_flush,
                 exmem_flush, fwd_a, fwd_b, stall_cnt, flush_cnt);
        chk("pc_write",    pc_write,    e_pc);
        chk("ifid_write",  ifid_write,  e_pc);
        chk("ifid_flush",  ifid_flush,  e_ifidf);
        chk("idex_flush",  idex_flush,  e_idexf);
        chk("exmem_flush", exmem_flush, e_exmemf);
        chk("fwd_a",       fwd_a,       e_fwd_a);
        chk("fwd_b",       fwd_b,       e_fwd_b);
        chk("run_state",   run_state,   e_state);
        chk("stall_cnt",   stall_cnt,   m_stall);
        chk("flush_cnt",   flush_cnt,   m_flush);
    endtask

    task automatic half_a(); @(negedge clk); compare_all(); endtask
    task automatic half_b(); @(posedge clk); model_step(); #1; endtask
    task automatic cycle();  half_a(); half_b(); endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0;
        idex_memread = 0; idex_regwrite = 0; idex_dst = 0;
        exmem_regwrite = 0; exmem_dst = 0; memwb_regwrite = 0; memwb_dst = 0;
        pcsrc = 0; jump = 0; halt_req = 0; step_req = 0; run_req = 0;
    endtask

    // Called at posedge+1; reset values are checked before any clock edge.
    task automatic do_reset();
        rst_n = 0;
        model_reset();
        #1 compare_all();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, memread, idex_rw;
        logic [4:0] idex_d;
        logic       exmem_rw;
        logic [4:0] exmem_d;
        logic       memwb_rw;
        logic [4:0] memwb_d;
        logic       br, jp;
        logic [4:0] want;   // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b11000};
        tbl[1]  = '{5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b00010};
        tbl[2]  = '{5'd1, 5'd3, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b11000};
        tbl[3]  = '{5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b00010};
        tbl[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b11000};
        tbl[5]  = '{5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'b11111};
        tbl[6]  = '{5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'b11100};
        tbl[7]  = '{5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'b11111};
        tbl[8]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0,
                    FWD ? 5'b11000 : 5'b00010};
        tbl[9]  = '{5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                    FWD ? 5'b11000 : 5'b00010};
        tbl[10] = '{5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 5'b11000};
        tbl[11] = '{5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'b00010};

        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // ---- table: one cycle from reset per vector ----
        for (int i = 0; i < 12; i++) begin
            do_reset();
            id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_uses_rt = tbl[i].uses_rt;
            idex_memread = tbl[i].memread; idex_regwrite = tbl[i].idex_rw; idex_dst = tbl[i].idex_d;
            exmem_regwrite = tbl[i].exmem_rw; exmem_dst = tbl[i].exmem_d;
            memwb_regwrite = tbl[i].memwb_rw; memwb_dst = tbl[i].memwb_d;
            pcsrc = tbl[i].br; jump = tbl[i].jp;
            half_a();
            chk($sformatf("tbl%0d_ctl", i),
                {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush}, tbl[i].want);
            half_b();
            clear_inputs();
        end

        // ---- lw $2 ; add $3,$2,$4 moving through the pipe ----
        do_reset();
        idex_memread = 1; idex_regwrite = 1; idex_dst = 2; id_rs = 2; id_rt = 4; id_uses_rt = 1;
        half_a();
        chk("lu_pc_write", pc_write, 0);
        chk("lu_idex_flush", idex_flush, 1);
        half_b();
        clear_inputs();
        exmem_regwrite = 1; exmem_dst = 2; id_rs = 2; id_rt = 4; id_uses_rt = 1;
        half_a();
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_next_pc_write", pc_write, FWD ? 1 : 0);
        half_b();
        clear_inputs();
        idex_regwrite = 1; idex_dst = 3; memwb_regwrite = 1; memwb_dst = 2;
        half_a();
        chk("lu_fwd_a_memwb", fwd_a, FWD ? 1 : 0);
        half_b();
        clear_inputs();

        // ---- load-use condition held: stall lasts exactly one cycle ----
        do_reset();
        idex_memread = 1; idex_dst = 9; id_rs = 9;
        half_a(); chk("hold_c1_pc_write", pc_write, 0); half_b();
        half_a(); chk("hold_c2_pc_write", pc_write, 1); half_b();
        clear_inputs();

        // ---- forwarding: EX/MEM priority, MEM/WB only, register 0 ----
        do_reset();
        id_rs = 2; id_rt = 2;
        cycle();
        clear_inputs();
        exmem_regwrite = 1; exmem_dst = 2; memwb_regwrite = 1; memwb_dst = 2; id_rs = 2;
        half_a();
        chk("fwd_a_exmem", fwd_a, FWD ? 2 : 0);
        chk("fwd_b_exmem", fwd_b, FWD ? 2 : 0);
        half_b();
        clear_inputs();
        memwb_regwrite = 1; memwb_dst = 2;
        half_a(); chk("fwd_a_memwb", fwd_a, FWD ? 1 : 0); half_b();
        clear_inputs();
        exmem_regwrite = 1; memwb_regwrite = 1;
        half_a(); chk("fwd_a_r0", fwd_a, 0); chk("fwd_b_r0", fwd_b, 0); half_b();
        clear_inputs();

        // ---- no-forwarding build: stall until EX/MEM writer retires ----
        do_reset();
        exmem_regwrite = 1; exmem_dst = 5; id_rs = 5;
        for (int k = 0; k < 3; k++) begin
            half_a();
            chk("raw_hold_pc_write", pc_write, FWD ? 1 : 0);
            chk("raw_hold_fwd_a", fwd_a, 0);
            half_b();
        end
        exmem_regwrite = 0;
        half_a(); chk("raw_clear_pc_write", pc_write, 1); half_b();
        clear_inputs();

        // ---- taken branch over a load-use ----
        do_reset();
        idex_memread = 1; idex_regwrite = 1; idex_dst = 2; id_rs = 2; pcsrc = 1;
        half_a();
        chk("br_lu_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        chk("br_lu_pc_write", pc_write, 1);
        half_b();
        clear_inputs();
        half_a();
        chk("br_lu_flush_cnt", flush_cnt, 1);
        chk("br_lu_stall_cnt", stall_cnt, 0);
        half_b();

        // ---- halt / drain / step / run ----
        do_reset();
        halt_req = 1;
        half_a(); chk("halt_req_state", run_state, 0); half_b();
        halt_req = 0;
        for (int k = 0; k < DRAIN_CYC; k++) begin
            halt_req = (k == 1);          // ignored while draining
            half_a();
            chk("drain_state", run_state, 1);
            chk("drain_pc_write", pc_write, 0);
            chk("drain_ifid_flush", ifid_flush, 1);
            half_b();
        end
        halt_req = 1;                     // ignored while halted
        half_a(); chk("halted_state", run_state, 2); chk("halted_pc_write", pc_write, 0); half_b();
        halt_req = 0; step_req = 1;
        half_a(); chk("halted_step_req", run_state, 2); half_b();
        step_req = 0;
        half_a(); chk("step_state", run_state, 3); chk("step_pc_write", pc_write, 1); half_b();
        for (int k = 0; k < DRAIN_CYC; k++) begin
            half_a(); chk("step_drain_state", run_state, 1); half_b();
        end
        half_a(); chk("step_halted", run_state, 2); half_b();
        run_req = 1; step_req = 1;
        cycle();
        clear_inputs();
        half_a(); chk("resume_state", run_state, 0); chk("resume_pc_write", pc_write, 1); half_b();

        // ---- reset in the middle of a drain ----
        do_reset();
        halt_req = 1; cycle();
        halt_req = 0; cycle();            // drain cycle 1
        #2;                                // mid drain cycle 2
        rst_n = 0; pcsrc = 1; idex_memread = 1; idex_dst = 3; id_rs = 3;
        model_reset();
        #1;
        compare_all();
        chk("async_rst_state", run_state, 0);
        chk("async_rst_pc_write", pc_write, 1);
        chk("async_rst_flush", {ifid_flush, idex_flush, exmem_flush}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        clear_inputs();
        half_a(); chk("post_rst_state", run_state, 0); half_b();

        // ---- randomized ----
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            id_rs          = 5'($urandom_range(0, 3));
            id_rt          = 5'($urandom_range(0, 3));
            id_uses_rt     = 1'($urandom_range(0, 1));
            idex_memread   = ($urandom_range(0, 2) == 0);
            idex_regwrite  = 1'($urandom_range(0, 1));
            idex_dst       = 5'($urandom_range(0, 3));
            exmem_regwrite = 1'($urandom_range(0, 1));
            exmem_dst      = 5'($urandom_range(0, 3));
            memwb_regwrite = 1'($urandom_range(0, 1));
            memwb_dst      = 5'($urandom_range(0, 3));
            pcsrc          = ($urandom_range(0, 7) == 0);
            jump           = ($urandom_range(0, 7) == 0);
            halt_req       = ($urandom_range(0, 19) == 0);
            step_req       = ($urandom_range(0, 5) == 0);
            run_req        = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, 16, width of the stall/flush statistics counters.
REQ-002 SHALL have parameter DRAIN_CYC, 4, cycles to empty ID/EX/MEM/WB after fetch stops.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID.
REQ-006 SHALL have port id_uses_rt  in  1  instruction in IF/ID reads rt (R-type, beq/bne, sw).
REQ-007 SHALL have ports idex_memread, idex_regwrite  in  1 each, and idex_dst  in  5  (ID/EX destination after RegDst mux).
REQ-008 SHALL have ports exmem_regwrite  in  1 and exmem_dst  in  5; memwb_regwrite  in  1 and memwb_dst  in  5.
REQ-009 SHALL have ports pcsrc  in  1  (branch resolved taken in MEM) and jump  in  1  (jump decoded in ID).
REQ-010 SHALL have ports halt_req, step_req, run_req  in  1 each  debug run-control pulses.
REQ-011 SHALL have outputs pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush  out  1 each.
REQ-012 SHALL have outputs fwd_a, fwd_b  out  2 each  (00 register file, 01 MEM/WB, 10 EX/MEM).
REQ-013 SHALL have outputs run_state  out  2, stall_cnt  out  CNT_W, flush_cnt  out  CNT_W.

Function
REQ-014 SHALL detect load-use: idex_memread and idex_dst!=0 and (idex_dst==id_rs or (id_uses_rt and idex_dst==id_rt)).
REQ-015 On load-use SHALL drive pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle; stall_cnt increments.
REQ-016 On pcsrc=1 SHALL assert ifid_flush, idex_flush, exmem_flush in that cycle; pcsrc overrides load-use stall (pc_write=1).
REQ-017 On jump=1 (no pcsrc) SHALL assert ifid_flush only; flush_cnt increments once per pcsrc or jump cycle.
REQ-018 Forwarding: fwd_a=10 if exmem_regwrite, exmem_dst!=0, exmem_dst==id_rs (sampled via ID/EX copy); else 01 on same test against MEM/WB; else 00; fwd_b likewise for rt; EX/MEM has priority.
REQ-019 Forwarding compare SHALL use rs/rt registered on each ifid->idex advance (internal 5-bit registers), cleared to 0 on idex_flush.
REQ-020 Run FSM states: RUN(00), DRAIN(01), HALTED(10), STEP(11); run_state outputs the encoding.
REQ-021 RUN: halt_req -> DRAIN. DRAIN: pc_write=0, ifid_write=0, ifid_flush=1, down-counter DRAIN_CYC-1..0; at 0 -> HALTED.
REQ-022 HALTED: pc_write=0, ifid_write=0; run_req -> RUN; step_req -> STEP; run_req wins if simultaneous.
REQ-023 STEP: exactly one fetch cycle with pc_write=1, ifid_write=1, then -> DRAIN.
REQ-024 halt_req in DRAIN/HALTED/STEP SHALL be ignored; halt_req together with pcsrc in RUN SHALL apply the flush, then enter DRAIN.
REQ-025 Counters SHALL saturate at all-ones; no increment in HALTED.

Reset
REQ-026 On rst_n=0 SHALL immediately force run_state=RUN, pc_write=1, ifid_write=1, all flushes 0, fwd_a=fwd_b=00, counters 0, internal rs/rt 0.
REQ-027 Reset mid-DRAIN or mid-STEP SHALL abandon the sequence; first cycle after release is RUN.

Configuration
REQ-028 With PIPELINE_CTRL_FWD_EN defined, SHALL implement REQ-018/019 forwarding.
REQ-029 Without it, fwd_a=fwd_b=00 constantly and the stall rule SHALL extend to any ID/EX or EX/MEM regwrite destination matching rs/rt (non-zero), stalling until clear.

Structure
REQ-030 Shared package pipeline_pkg SHALL hold run-state enum, forward-select constants (FWD_RF, FWD_MEMWB, FWD_EXMEM).
REQ-031 Run-control FSM SHALL be sub-module run_ctrl_fsm; hazard/forward logic stays in pipeline_ctrl.

Verification
REQ-032 lw $2; add $3,$2,$4: idex_memread=1, idex_dst=2, id_rs=2 -> one cycle pc_write=0, idex_flush=1, stall_cnt=1.
REQ-033 add $2 in EX/MEM and MEM/WB, next reads rs=2 -> fwd_a=10; only MEM/WB match -> 01; dst=0 -> 00.
REQ-034 pcsrc=1 coincident with load-use -> all three flushes 1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
REQ-035 halt_req in RUN -> DRAIN for 4 cycles, run_state=10; step_req -> one cycle pc_write=1, then DRAIN 4 cycles, HALTED.
REQ-036 rst_n low during DRAIN cycle 2 -> outputs at reset values asynchronously; after release run_state=00.
REQ-037 Without PIPELINE_CTRL_FWD_EN: exmem_regwrite=1, exmem_dst=5, id_rs=5 -> pc_write=0 until exmem_regwrite drops; fwd_a=00 throughout.
